layer_sched_fsm: RTL
====================

LAYER_SCHED_FSM -- requirements
Module: layer_sched_fsm

Interface
REQ-001 SHALL have parameter N_LOG, default 10, log2 of code length N.
REQ-002 SHALL have parameter ID_COUNTER_WIDTH, default 10, bit-index width.
REQ-003 SHALL have parameter LAYER_WIDTH, default 4, layer-number width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 11, LLR memory address width.
REQ-005 SHALL have parameter PE_NUM, default 64 (power of 2), processing elements per beat.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have ports start (input, 1, begin codeword), busy (output, 1), done (output, 1, one-cycle pulse).
REQ-009 SHALL have port bit_id, output, ID_COUNTER_WIDTH, registered index of the bit being decoded; it drives the upstream start-layer calculator.
REQ-010 SHALL have ports start_layer_num (input, LAYER_WIDTH) and start_layer_init_addr (input, ADDR_WIDTH), returned combinationally for bit_id.
REQ-011 SHALL have ports op_valid (output, 1), op_ready (input, 1), op_type (output, 1, 0=F, 1=G), op_layer (output, LAYER_WIDTH), op_rd_addr and op_wr_addr (output, ADDR_WIDTH each), op_lanes (output, log2(PE_NUM)+1).
REQ-012 SHALL have ports leaf_valid (output, 1, hard decision requested for bit_id) and leaf_ack (input, 1).

Function
REQ-013 SHALL implement states IDLE, LOAD, OP, LEAF and DONE.
- IDLE->LOAD on start.
- LOAD->OP after one cycle.
- OP->LEAF after the final beat of layer 0 is accepted.
- LEAF->LOAD on leaf_ack with bit_id incremented.
- LEAF->DONE on leaf_ack when bit_id==N-1.
- DONE->IDLE after one cycle.
REQ-014 SHALL sample start_layer_num and start_layer_init_addr in LOAD only; inputs are ignored in all other states.
REQ-015 SHALL issue the first op at layer min(s, N_LOG-1), where s is the sampled start_layer_num.
- If s==N_LOG: first op is F, rd base = init address, wr base = (init>>1)|2^(ADDR_WIDTH-1).
- Otherwise: first op is G, rd base = (init<<1) truncated to ADDR_WIDTH, wr base = init.
REQ-016 SHALL follow the first op with F ops on each lower layer down to 0.
- Each next rd base = previous wr base.
- Each next wr base = (previous wr base>>1)|2^(ADDR_WIDTH-1).
REQ-017 SHALL split an op at layer k into max(1, 2^k/PE_NUM) beats.
- op_lanes = min(2^k, PE_NUM).
- Addresses advance 2*PE_NUM (rd) and PE_NUM (wr) per accepted beat.
REQ-018 SHALL advance a beat only when op_valid && op_ready; all op_* outputs SHALL hold stable while op_ready is low.
REQ-019 SHALL assert first op_valid two cycles after start is sampled in IDLE; there SHALL be no bubble between beats or between layers when op_ready stays high.
REQ-020 SHALL ignore start when not in IDLE and leaf_ack when not in LEAF.
REQ-021 SHALL hold busy high in LOAD, OP and LEAF.
REQ-022 SHALL wrap bit_id to 0 on entering DONE.

Reset
REQ-023 SHALL, on rst_n low at a clock edge (including mid-op), enter IDLE and clear bit_id, op_*, leaf_valid, busy and done to 0; any partial op is abandoned.

Configuration
REQ-024 SHALL, with LAYER_SCHED_PERF_CNT_EN defined, add outputs beat_count (16-bit, accepted beats) and stall_count (16-bit, cycles with op_valid && !op_ready).
- Both counters clear on start and saturate at 16'hFFFF.
- Without the macro, these ports and their logic are absent.

Structure
REQ-025 SHALL take N_LOG, ADDR_WIDTH, LAYER_WIDTH, PE_NUM defaults, the op_type enum (OP_F, OP_G) and the state enum from shared package polar_dec_pkg.
REQ-026 SHALL place the beat/address stepper (beat counter, rd/wr address increment, lanes) in sub-module layer_beat_step.

Verification
REQ-027 SHALL cover bit_id=0 (s=10, init 0x000): 10 F ops on layers 9..0, beats 8,4,2,1,1,1,1,1,1,1 (21 total); first beat rd 0x000, wr 0x400.
REQ-028 SHALL cover bit_id=1 (s=0, init 0x7FE): one G beat, layer 0, rd 0x7FC, wr 0x7FE, lanes 1; then leaf_valid.
REQ-029 SHALL cover bit_id=512 (s=9, init 0x400): G on layer 9, rd 0x000, wr 0x400, 8 beats; then F on layers 8..0, layer 8 rd 0x400, wr 0x600.
REQ-030 SHALL cover op_ready low for 3 cycles mid-layer: op_* held unchanged and the beat sequence resumes intact.
REQ-031 SHALL cover rst_n low during OP on layer 5: next cycle IDLE, all outputs 0; a new start restarts at bit_id 0.
REQ-032 SHALL cover leaf_ack at bit_id 1023: done pulses once, busy falls, bit_id returns to 0.

Source files
------------

// File: rtl/polar_dec_pkg.sv
// Shared types and default sizes for the polar decoder layer scheduler.
package polar_dec_pkg;

    localparam int N_LOG_DEF       = 10;
    localparam int ADDR_WIDTH_DEF  = 11;
    localparam int LAYER_WIDTH_DEF = 4;
    localparam int PE_NUM_DEF      = 64;

    // F combines two LLR halves, G uses the partial-sum hard decisions.
    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } op_type_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OP,
        LEAF,
        DONE
    } state_e;

endpackage

// File: rtl/layer_beat_step.sv
// Beat/address stepper: for a layer and beat index, gives beat addresses, lane count
// and whether this is the final beat of the layer.
module layer_beat_step
    import polar_dec_pkg::*;
#(
    parameter int LAYER_WIDTH = LAYER_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int PE_NUM      = PE_NUM_DEF,
    parameter int BEAT_WIDTH  = N_LOG_DEF
) (
    input  logic [LAYER_WIDTH-1:0]     i_layer,
    input  logic [BEAT_WIDTH-1:0]      i_beat,
    input  logic [ADDR_WIDTH-1:0]      i_rd_base,
    input  logic [ADDR_WIDTH-1:0]      i_wr_base,
    output logic [ADDR_WIDTH-1:0]      o_rd_addr,
    output logic [ADDR_WIDTH-1:0]      o_wr_addr,
    output logic [$clog2(PE_NUM):0]    o_lanes,
    output logic                       o_last
);

    localparam int PE_LOG = $clog2(PE_NUM);
    localparam int LANE_W = PE_LOG + 1;

    logic [BEAT_WIDTH-1:0] w_last_beat;

    // Layers wider than the PE array take 2^k/PE_NUM full beats; narrower ones take one partial beat.
    always_comb begin
        w_last_beat = '0;
        o_lanes     = LANE_W'(PE_NUM);
        if (int'(i_layer) >= PE_LOG) begin
            w_last_beat = BEAT_WIDTH'((1 << (int'(i_layer) - PE_LOG)) - 1);
        end else begin
            o_lanes = LANE_W'(1) << i_layer;
        end
    end

    assign o_last    = (i_beat == w_last_beat);
    assign o_rd_addr = i_rd_base + ADDR_WIDTH'(32'(i_beat) * 32'(2 * PE_NUM));
    assign o_wr_addr = i_wr_base + ADDR_WIDTH'(32'(i_beat) * 32'(PE_NUM));

endmodule

// File: rtl/layer_sched_fsm.sv
// Layer scheduler for a successive-cancellation polar decoder: walks the F/G op sequence
// from each bit's start layer down to layer 0, then requests a leaf hard decision.
// Optional LAYER_SCHED_PERF_CNT_EN adds beat_count/stall_count performance counters.
module layer_sched_fsm
    import polar_dec_pkg::*;
#(
    parameter int N_LOG            = N_LOG_DEF,
    parameter int ID_COUNTER_WIDTH = 10,
    parameter int LAYER_WIDTH      = LAYER_WIDTH_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int PE_NUM           = PE_NUM_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [ID_COUNTER_WIDTH-1:0] bit_id,
    input  logic [LAYER_WIDTH-1:0]      start_layer_num,
    input  logic [ADDR_WIDTH-1:0]       start_layer_init_addr,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic                        op_type,
    output logic [LAYER_WIDTH-1:0]      op_layer,
    output logic [ADDR_WIDTH-1:0]       op_rd_addr,
    output logic [ADDR_WIDTH-1:0]       op_wr_addr,
    output logic [$clog2(PE_NUM):0]     op_lanes,
    output logic                        leaf_valid,
    input  logic                        leaf_ack
`ifdef LAYER_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]                 beat_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0]       ADDR_MSB  = {1'b1, {(ADDR_WIDTH - 1){1'b0}}};
    localparam logic [ID_COUNTER_WIDTH-1:0] BIT_LAST  = ID_COUNTER_WIDTH'((1 << N_LOG) - 1);
    localparam logic [LAYER_WIDTH-1:0]      TOP_LAYER = LAYER_WIDTH'(N_LOG - 1);

    state_e                        r_state, w_state_nxt;
    logic [ID_COUNTER_WIDTH-1:0]   r_bit_id, w_bit_id_nxt;
    logic [LAYER_WIDTH-1:0]        r_layer, w_layer_nxt;
    op_type_e                      r_type, w_type_nxt;
    logic [ADDR_WIDTH-1:0]         r_rd_base, w_rd_base_nxt;
    logic [ADDR_WIDTH-1:0]         r_wr_base, w_wr_base_nxt;
    logic [N_LOG-1:0]              r_beat, w_beat_nxt;

    logic [ADDR_WIDTH-1:0]         w_rd_addr, w_wr_addr;
    logic [$clog2(PE_NUM):0]       w_lanes;
    logic                          w_last;
    logic                          w_accept;

    layer_beat_step #(
        .LAYER_WIDTH (LAYER_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PE_NUM      (PE_NUM),
        .BEAT_WIDTH  (N_LOG)
    ) u_step (
        .i_layer   (r_layer),
        .i_beat    (r_beat),
        .i_rd_base (r_rd_base),
        .i_wr_base (r_wr_base),
        .o_rd_addr (w_rd_addr),
        .o_wr_addr (w_wr_addr),
        .o_lanes   (w_lanes),
        .o_last    (w_last)
    );

    assign w_accept = op_valid && op_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit index, current layer and its base addresses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_id  <= '0;
            r_layer   <= '0;
            r_type    <= OP_F;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_beat    <= '0;
        end else begin
            r_bit_id  <= w_bit_id_nxt;
            r_layer   <= w_layer_nxt;
            r_type    <= w_type_nxt;
            r_rd_base <= w_rd_base_nxt;
            r_wr_base <= w_wr_base_nxt;
            r_beat    <= w_beat_nxt;
        end
    end

    // Next-state and layer walk.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_id_nxt  = r_bit_id;
        w_layer_nxt   = r_layer;
        w_type_nxt    = r_type;
        w_rd_base_nxt = r_rd_base;
        w_wr_base_nxt = r_wr_base;
        w_beat_nxt    = r_beat;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = OP;
                w_beat_nxt  = '0;
                // A start layer of N_LOG means the bit begins at the root with an F.
                if (int'(start_layer_num) >= N_LOG) begin
                    w_layer_nxt   = TOP_LAYER;
                    w_type_nxt    = OP_F;
                    w_rd_base_nxt = start_layer_init_addr;
                    w_wr_base_nxt = (start_layer_init_addr >> 1) | ADDR_MSB;
                end else begin
                    w_layer_nxt   = start_layer_num;
                    w_type_nxt    = OP_G;
                    w_rd_base_nxt = start_layer_init_addr << 1;
                    w_wr_base_nxt = start_layer_init_addr;
                end
            end
            OP: begin
                if (w_accept) begin
                    if (!w_last) begin
                        w_beat_nxt = r_beat + N_LOG'(1);
                    end else begin
                        w_beat_nxt = '0;
                        if (r_layer == '0) begin
                            w_state_nxt = LEAF;
                        end else begin
                            // Each lower layer reads what the layer above just wrote.
                            w_layer_nxt   = r_layer - LAYER_WIDTH'(1);
                            w_type_nxt    = OP_F;
                            w_rd_base_nxt = r_wr_base;
                            w_wr_base_nxt = (r_wr_base >> 1) | ADDR_MSB;
                        end
                    end
                end
            end
            LEAF: begin
                if (leaf_ack) begin
                    if (r_bit_id == BIT_LAST) begin
                        w_state_nxt  = DONE;
                        w_bit_id_nxt = '0;
                    end else begin
                        w_state_nxt  = LOAD;
                        w_bit_id_nxt = r_bit_id + ID_COUNTER_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy       = (r_state == LOAD) || (r_state == OP) || (r_state == LEAF);
    assign done       = (r_state == DONE);
    assign leaf_valid = (r_state == LEAF);
    assign bit_id     = r_bit_id;
    assign op_valid   = (r_state == OP);

    // Op fields read as zero outside OP so idle outputs are clean.
    assign op_type    = op_valid ? logic'(r_type) : 1'b0;
    assign op_layer   = op_valid ? r_layer : '0;
    assign op_rd_addr = op_valid ? w_rd_addr : '0;
    assign op_wr_addr = op_valid ? w_wr_addr : '0;
    assign op_lanes   = op_valid ? w_lanes : '0;

`ifdef LAYER_SCHED_PERF_CNT_EN
    logic [15:0] r_beat_cnt, r_stall_cnt;

    // Saturating accepted-beat and backpressure-cycle counters, cleared by a new codeword.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (r_beat_cnt != 16'hFFFF)) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (op_valid && !op_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign beat_count  = r_beat_cnt;
    assign stall_count = r_stall_cnt;
`endif

endmodule
